// File: rtl/lpc_capture_scheduler_if.sv
// Record and byte-stream bundle for lpc_capture_scheduler.
// The slave modport is the scheduler; the master modport drives records and sinks the stream.
interface lpc_capture_scheduler_if #(
    parameter int DEPTH_LOG2 = 2
);
    logic [3:0]          in_cyctype_dir;
    logic [31:0]         in_addr;
    logic [31:0]         in_data;
    logic [2:0]          in_data_size;
    logic                in_valid;
    logic [7:0]          tx_data;
    logic                tx_valid;
    logic                tx_ready;
    logic                overflow;
    logic [DEPTH_LOG2:0] fifo_level;

    modport master (
        output in_cyctype_dir, in_addr, in_data, in_data_size, in_valid, tx_ready,
        input  tx_data, tx_valid, overflow, fifo_level
    );

    modport slave (
        input  in_cyctype_dir, in_addr, in_data, in_data_size, in_valid, tx_ready,
        output tx_data, tx_valid, overflow, fifo_level
    );
endinterface

// File: rtl/lpc_capture_scheduler.sv
// Queues decoded LPC records and serializes each as a 10-byte valid/ready frame.
// Optional cycle-type filter enabled by defining LPC_CAPTURE_FILTER_EN (adds filter_mask).
module lpc_capture_scheduler #(
    parameter int DEPTH_LOG2 = 2
) (
    input  logic lpc_clock,
    input  logic lpc_reset,
`ifdef LPC_CAPTURE_FILTER_EN
    input  logic [3:0] filter_mask,
`endif
    lpc_capture_scheduler_if.slave bus
);
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] FULL_LEVEL = {1'b1, {DEPTH_LOG2{1'b0}}};

    typedef enum logic {IDLE, SEND} state_t;

    state_t                  state;
    logic [3:0]              idx;
    logic [7:0]              tx_data;
    logic                    tx_valid;
    logic                    overflow;
    logic [DEPTH_LOG2:0]     level;
    logic [DEPTH_LOG2:0]     level_next;
    logic [DEPTH_LOG2-1:0]   wr_ptr;
    logic [DEPTH_LOG2-1:0]   rd_ptr;
    logic [70:0]             mem [DEPTH];
    logic [70:0]             head;
    logic                    accept;
    logic                    push;
    logic                    pop;

    function automatic logic [7:0] frame_byte(input logic [70:0] rec, input logic [3:0] i);
        logic [7:0] b;
        case (i)
            4'd0:    b = 8'hA5;
            4'd1:    b = {rec[70:67], 1'b0, rec[66:64]};
            4'd2:    b = rec[63:56];
            4'd3:    b = rec[55:48];
            4'd4:    b = rec[47:40];
            4'd5:    b = rec[39:32];
            4'd6:    b = rec[31:24];
            4'd7:    b = rec[23:16];
            4'd8:    b = rec[15:8];
            default: b = rec[7:0];
        endcase
        return b;
    endfunction

    always_comb begin
`ifdef LPC_CAPTURE_FILTER_EN
        accept = bus.in_valid & filter_mask[bus.in_cyctype_dir[3:2]];
`else
        accept = bus.in_valid;
`endif
        head = mem[rd_ptr];
        // tx_valid is always 1 in SEND, so tx_ready alone completes the handshake
        pop  = (state == SEND) && bus.tx_ready && (idx == 4'd9);
        push = accept && ((level < FULL_LEVEL) || pop);
        case ({push, pop})
            2'b10:   level_next = level + 1'b1;
            2'b01:   level_next = level - 1'b1;
            default: level_next = level;
        endcase
    end

    always_ff @(posedge lpc_clock) begin
        if (push) begin
            mem[wr_ptr] <= {bus.in_cyctype_dir, bus.in_data_size, bus.in_addr, bus.in_data};
        end
    end

    always_ff @(posedge lpc_clock or negedge lpc_reset) begin
        if (!lpc_reset) begin
            state    <= IDLE;
            idx      <= 4'd0;
            tx_valid <= 1'b0;
            tx_data  <= 8'h00;
            overflow <= 1'b0;
            level    <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
        end else begin
            if (accept && !push) overflow <= 1'b1;
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            level <= level_next;
            case (state)
                IDLE: begin
                    if (level != '0) begin
                        state    <= SEND;
                        idx      <= 4'd0;
                        tx_valid <= 1'b1;
                        tx_data  <= 8'hA5;
                    end
                end
                SEND: begin
                    if (bus.tx_ready) begin
                        if (idx == 4'd9) begin
                            // Next frame follows without a gap when anything remains queued
                            if (level_next != '0) begin
                                idx     <= 4'd0;
                                tx_data <= 8'hA5;
                            end else begin
                                state    <= IDLE;
                                tx_valid <= 1'b0;
                            end
                        end else begin
                            idx     <= idx + 4'd1;
                            tx_data <= frame_byte(head, idx + 4'd1);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.tx_data    = tx_data;
    assign bus.tx_valid   = tx_valid;
    assign bus.overflow   = overflow;
    assign bus.fifo_level = level;
endmodule

// File: tb/tb_lpc_capture_scheduler.sv
// Directed bench for lpc_capture_scheduler: framing, backpressure, overflow, reset, streaming.
module tb_lpc_capture_scheduler;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
`ifdef LPC_CAPTURE_FILTER_EN
    logic [3:0] filter_mask = 4'b1111;
`endif

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    logic [7:0] rxq[$];
    int tq[$];

    logic [7:0] exp_io [10] = '{8'hA5, 8'h00, 8'h00, 8'h00, 8'h7F, 8'hE5, 8'h00, 8'h00, 8'h00, 8'h6C};
    logic [7:0] exp_mem[10] = '{8'hA5, 8'h43, 8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC, 8'hDE, 8'hF0};

    lpc_capture_scheduler_if #(.DEPTH_LOG2(2)) bus ();

    lpc_capture_scheduler #(.DEPTH_LOG2(2)) dut (
        .lpc_clock  (clk),
        .lpc_reset  (rst_n),
`ifdef LPC_CAPTURE_FILTER_EN
        .filter_mask(filter_mask),
`endif
        .bus        (bus.slave)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rst_n && bus.tx_valid && bus.tx_ready) begin
            rxq.push_back(bus.tx_data);
            tq.push_back(cyc);
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_rec(input logic [3:0] ct, input logic [31:0] a, input logic [31:0] d,
                           input logic [2:0] sz);
        bus.in_valid       = 1'b1;
        bus.in_cyctype_dir = ct;
        bus.in_addr        = a;
        bus.in_data        = d;
        bus.in_data_size   = sz;
    endtask

    task automatic wait_bytes(input int n, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (rxq.size() >= n) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        if (rxq.size() >= n) ok = 1'b1;
    endtask

    task automatic test_reset();
        #1;
        checks++; if (bus.tx_valid !== 1'b0) begin errors++; $display("FAIL reset_tx_valid got %b want 0", bus.tx_valid); end
        checks++; if (bus.tx_data !== 8'h00) begin errors++; $display("FAIL reset_tx_data got %h want 00", bus.tx_data); end
        checks++; if (bus.overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow got %b want 0", bus.overflow); end
        checks++; if (bus.fifo_level !== 3'd0) begin errors++; $display("FAIL reset_level got %0d want 0", bus.fifo_level); end
        #11;
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_single_io();
        bit ok;
        rxq.delete(); tq.delete();
        bus.tx_ready = 1'b1;
        set_rec(4'b0000, 32'h0000_7fe5, 32'h0000_006c, 3'd0);
        tick();
        bus.in_valid = 1'b0;
        checks++; if (bus.tx_valid !== 1'b0) begin errors++; $display("FAIL io_valid_early got %b want 0", bus.tx_valid); end
        checks++; if (bus.fifo_level !== 3'd1) begin errors++; $display("FAIL io_level_push got %0d want 1", bus.fifo_level); end
        tick();
        checks++; if (bus.tx_valid !== 1'b1 || bus.tx_data !== 8'hA5) begin errors++; $display("FAIL io_latency got valid %b data %h want 1 a5", bus.tx_valid, bus.tx_data); end
        wait_bytes(10, 40, ok);
        checks++; if (!ok) begin errors++; $display("FAIL io_timeout got %0d bytes want 10", rxq.size()); end
        repeat (4) tick();
        checks++; if (rxq.size() != 10) begin errors++; $display("FAIL io_count got %0d want 10", rxq.size()); end
        for (int i = 0; i < 10 && i < rxq.size(); i++) begin
            checks++; if (rxq[i] !== exp_io[i]) begin errors++; $display("FAIL io_byte%0d got %h want %h", i, rxq[i], exp_io[i]); end
        end
        checks++; if (bus.fifo_level !== 3'd0 || bus.tx_valid !== 1'b0) begin errors++; $display("FAIL io_drain got level %0d valid %b want 0 0", bus.fifo_level, bus.tx_valid); end
    endtask

    task automatic test_backpressure();
        bit ok;
        rxq.delete(); tq.delete();
        bus.tx_ready = 1'b1;
        set_rec(4'b0100, 32'h1234_5678, 32'h9abc_def0, 3'd3);
        tick();
        bus.in_valid = 1'b0;
        wait_bytes(4, 40, ok);
        checks++; if (!ok) begin errors++; $display("FAIL bp_first_timeout got %0d bytes want 4", rxq.size()); end
        bus.tx_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++; if (bus.tx_valid !== 1'b1 || bus.tx_data !== 8'h56) begin errors++; $display("FAIL bp_stall%0d got valid %b data %h want 1 56", i, bus.tx_valid, bus.tx_data); end
        end
        bus.tx_ready = 1'b1;
        wait_bytes(10, 40, ok);
        repeat (4) tick();
        checks++; if (rxq.size() != 10) begin errors++; $display("FAIL bp_count got %0d want 10", rxq.size()); end
        for (int i = 0; i < 10 && i < rxq.size(); i++) begin
            checks++; if (rxq[i] !== exp_mem[i]) begin errors++; $display("FAIL bp_byte%0d got %h want %h", i, rxq[i], exp_mem[i]); end
        end
    endtask

    task automatic test_overflow();
        bit ok;
        rxq.delete(); tq.delete();
        bus.tx_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            set_rec(4'b0000, 32'h0000_0110 + k, k, 3'd0);
            tick();
        end
        bus.in_valid = 1'b0;
        checks++; if (bus.fifo_level !== 3'd4) begin errors++; $display("FAIL ovf_level got %0d want 4", bus.fifo_level); end
        checks++; if (bus.overflow !== 1'b1) begin errors++; $display("FAIL ovf_flag got %b want 1", bus.overflow); end
        checks++; if (bus.tx_valid !== 1'b1 || bus.tx_data !== 8'hA5) begin errors++; $display("FAIL ovf_stall got valid %b data %h want 1 a5", bus.tx_valid, bus.tx_data); end
        bus.tx_ready = 1'b1;
        wait_bytes(40, 120, ok);
        repeat (15) tick();
        checks++; if (rxq.size() != 40) begin errors++; $display("FAIL ovf_count got %0d want 40", rxq.size()); end
        for (int k = 0; k < 4 && rxq.size() >= 40; k++) begin
            checks++; if (rxq[10*k] !== 8'hA5) begin errors++; $display("FAIL ovf_sync%0d got %h want a5", k, rxq[10*k]); end
            checks++; if (rxq[10*k+5] !== 8'h10 + 8'(k)) begin errors++; $display("FAIL ovf_addr%0d got %h want %h", k, rxq[10*k+5], 8'h10 + 8'(k)); end
        end
        checks++; if (bus.fifo_level !== 3'd0 || bus.overflow !== 1'b1) begin errors++; $display("FAIL ovf_after got level %0d ovf %b want 0 1", bus.fifo_level, bus.overflow); end
    endtask

    task automatic test_reset_midframe();
        bit ok;
        rxq.delete(); tq.delete();
        bus.tx_ready = 1'b1;
        set_rec(4'b0100, 32'h1234_5678, 32'h9abc_def0, 3'd3);
        tick();
        bus.in_valid = 1'b0;
        wait_bytes(4, 40, ok);
        checks++; if (!ok) begin errors++; $display("FAIL rst_pre_timeout got %0d bytes want 4", rxq.size()); end
        rst_n = 1'b0;
        #1;
        checks++; if (bus.tx_valid !== 1'b0) begin errors++; $display("FAIL rst_mid_valid got %b want 0", bus.tx_valid); end
        checks++; if (bus.fifo_level !== 3'd0) begin errors++; $display("FAIL rst_mid_level got %0d want 0", bus.fifo_level); end
        checks++; if (bus.overflow !== 1'b0) begin errors++; $display("FAIL rst_mid_overflow got %b want 0", bus.overflow); end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        rxq.delete(); tq.delete();
        set_rec(4'b0000, 32'h0000_7fe5, 32'h0000_006c, 3'd0);
        tick();
        bus.in_valid = 1'b0;
        wait_bytes(10, 40, ok);
        repeat (4) tick();
        checks++; if (rxq.size() != 10) begin errors++; $display("FAIL rst_post_count got %0d want 10", rxq.size()); end
        for (int i = 0; i < 10 && i < rxq.size(); i++) begin
            checks++; if (rxq[i] !== exp_io[i]) begin errors++; $display("FAIL rst_post_byte%0d got %h want %h", i, rxq[i], exp_io[i]); end
        end
    endtask

    task automatic test_back_to_back();
        bit ok;
        rxq.delete(); tq.delete();
        bus.tx_ready = 1'b1;
        set_rec(4'b0000, 32'h0000_0080, 32'h0000_0011, 3'd0);
        tick();
        set_rec(4'b0100, 32'h0000_0081, 32'h0000_0022, 3'd1);
        tick();
        bus.in_valid = 1'b0;
        wait_bytes(20, 60, ok);
        repeat (4) tick();
        checks++; if (rxq.size() != 20) begin errors++; $display("FAIL b2b_count got %0d want 20", rxq.size()); end
        if (rxq.size() >= 20) begin
            checks++; if (tq[19] - tq[0] != 19) begin errors++; $display("FAIL b2b_gap got span %0d want 19", tq[19] - tq[0]); end
            checks++; if (rxq[5] !== 8'h80) begin errors++; $display("FAIL b2b_addr0 got %h want 80", rxq[5]); end
            checks++; if (rxq[10] !== 8'hA5) begin errors++; $display("FAIL b2b_sync1 got %h want a5", rxq[10]); end
            checks++; if (rxq[11] !== 8'h41) begin errors++; $display("FAIL b2b_hdr1 got %h want 41", rxq[11]); end
            checks++; if (rxq[15] !== 8'h81) begin errors++; $display("FAIL b2b_addr1 got %h want 81", rxq[15]); end
            checks++; if (rxq[19] !== 8'h22) begin errors++; $display("FAIL b2b_data1 got %h want 22", rxq[19]); end
        end
    endtask

`ifdef LPC_CAPTURE_FILTER_EN
    task automatic test_filter();
        bit ok;
        rxq.delete(); tq.delete();
        filter_mask  = 4'b0001;
        bus.tx_ready = 1'b1;
        set_rec(4'b0110, 32'h0000_1000, 32'h0000_0055, 3'd0);
        tick();
        set_rec(4'b0000, 32'h0000_7fe5, 32'h0000_006c, 3'd0);
        tick();
        bus.in_valid = 1'b0;
        wait_bytes(10, 40, ok);
        repeat (15) tick();
        checks++; if (rxq.size() != 10) begin errors++; $display("FAIL filt_count got %0d want 10", rxq.size()); end
        for (int i = 0; i < 10 && i < rxq.size(); i++) begin
            checks++; if (rxq[i] !== exp_io[i]) begin errors++; $display("FAIL filt_byte%0d got %h want %h", i, rxq[i], exp_io[i]); end
        end
        checks++; if (bus.overflow !== 1'b0) begin errors++; $display("FAIL filt_overflow got %b want 0", bus.overflow); end
        filter_mask = 4'b1111;
    endtask
`endif

    initial begin
        bus.in_valid       = 1'b0;
        bus.in_cyctype_dir = 4'd0;
        bus.in_addr        = 32'd0;
        bus.in_data        = 32'd0;
        bus.in_data_size   = 3'd0;
        bus.tx_ready       = 1'b0;
        test_reset();
        test_single_io();
        test_backpressure();
        test_overflow();
        test_reset_midframe();
        test_back_to_back();
`ifdef LPC_CAPTURE_FILTER_EN
        test_filter();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
